// File: rtl/cav_relock_pkg.sv
// Shared definitions for the cavity auto-relock controller: default widths
// and the state encoding seen on the state output.
package cav_relock_pkg;

    localparam int SIG_W_DEF = 25;
    localparam int CNT_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam logic [7:0] RELOCK_MAX = 8'hFF;

endpackage

// File: rtl/cav_ramp_gen.sv
// Triangle sweep generator. It bounces between sweep_min and sweep_max,
// moving by sweep_step per enabled clock. load restarts it at sweep_min, heading up.
module cav_ramp_gen
    import cav_relock_pkg::*;
#(
    parameter int SIG_W = SIG_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    run,
    input  logic signed [SIG_W-1:0] sweep_min,
    input  logic signed [SIG_W-1:0] sweep_max,
    input  logic        [SIG_W-2:0] sweep_step,
    output logic signed [SIG_W-1:0] value,
    output logic signed [SIG_W-1:0] value_next
);

    logic                    dir_up;
    logic                    dir_up_next;
    logic signed [SIG_W:0]   ext_val;
    logic signed [SIG_W:0]   ext_min;
    logic signed [SIG_W:0]   ext_max;
    logic signed [SIG_W:0]   ext_step;
    logic signed [SIG_W:0]   lim_up;
    logic signed [SIG_W:0]   lim_dn;
    logic signed [SIG_W-1:0] step_s;

    // Boundary tests use one extra bit so that value +/- step can never wrap.
    always_comb begin
        ext_val  = {value[SIG_W-1], value};
        ext_min  = {sweep_min[SIG_W-1], sweep_min};
        ext_max  = {sweep_max[SIG_W-1], sweep_max};
        ext_step = {2'b00, sweep_step};
        lim_up   = ext_max - ext_step;
        lim_dn   = ext_min + ext_step;
        step_s   = {1'b0, sweep_step};
    end

    always_comb begin
        value_next  = value;
        dir_up_next = dir_up;
        if (load) begin
            value_next  = sweep_min;
            dir_up_next = 1'b1;
        end else if (run) begin
            if (ext_min > ext_max) begin
                value_next = sweep_min;
            end else if (sweep_step != '0) begin
                if (dir_up) begin
                    if (ext_val >= lim_up) begin
                        value_next  = sweep_max;
                        dir_up_next = 1'b0;
                    end else begin
                        value_next = value + step_s;
                    end
                end else begin
                    if (ext_val <= lim_dn) begin
                        value_next  = sweep_min;
                        dir_up_next = 1'b1;
                    end else begin
                        value_next = value - step_s;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value  <= sweep_min;
            dir_up <= 1'b1;
        end else begin
            value  <= value_next;
            dir_up <= dir_up_next;
        end
    end

endmodule

// File: rtl/cav_relock.sv
// Cavity auto-relock controller. It sweeps the actuator until transmission
// appears, hands over to the PID, and re-sweeps after a debounced lock loss.
module cav_relock
    import cav_relock_pkg::*;
#(
    parameter int SIG_W = SIG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [SIG_W-1:0] trans,
    input  logic signed [SIG_W-1:0] thr_lock,
    input  logic signed [SIG_W-1:0] thr_lost,
    input  logic signed [SIG_W-1:0] sweep_min,
    input  logic signed [SIG_W-1:0] sweep_max,
    input  logic        [SIG_W-2:0] sweep_step,
    input  logic        [CNT_W-1:0] settle_cyc,
    input  logic        [CNT_W-1:0] lost_cyc,
    input  logic signed [SIG_W-1:0] pid_out,
    output logic                    pid_on,
    output logic                    pid_hld,
    output logic signed [SIG_W-1:0] dac_out,
    output logic        [1:0]       state,
    output logic                    locked,
    output logic        [7:0]       relock_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t                  st;
    logic [CNT_W-1:0]        timer;
    logic [CNT_W-1:0]        loss;
    logic [CNT_W-1:0]        settle_lim;
    logic [CNT_W-1:0]        lost_lim;
    logic signed [SIG_W-1:0] offset;
    logic signed [SIG_W-1:0] ramp_val;
    logic signed [SIG_W-1:0] ramp_next;
    logic signed [SIG_W:0]   sum_w;
    logic signed [SIG_W:0]   ext_min;
    logic signed [SIG_W:0]   ext_max;
    logic signed [SIG_W-1:0] servo_dac;
    logic                    lock_hit;
    logic                    lost_hit;
    logic                    ramp_load;
    logic                    ramp_run;

    assign state = st;

    // The ramp holds still on the lock-detect edge so the frozen offset is
    // exactly the value that produced the transmission peak.
    assign lock_hit  = (trans >= thr_lock);
    assign lost_hit  = (trans < thr_lost);
    assign ramp_load = (st == ST_IDLE);
    assign ramp_run  = en && (st == ST_SWEEP) && !lock_hit;

    cav_ramp_gen #(
        .SIG_W (SIG_W)
    ) u_ramp (
        .clk        (clk),
        .rst        (rst),
        .load       (ramp_load),
        .run        (ramp_run),
        .sweep_min  (sweep_min),
        .sweep_max  (sweep_max),
        .sweep_step (sweep_step),
        .value      (ramp_val),
        .value_next (ramp_next)
    );

    // A programmed count of zero behaves as one cycle.
    always_comb begin
        settle_lim = (settle_cyc == '0) ? '0 : settle_cyc - CNT_ONE;
        lost_lim   = (lost_cyc == '0) ? '0 : lost_cyc - CNT_ONE;
    end

    always_comb begin
        sum_w   = {offset[SIG_W-1], offset} + {pid_out[SIG_W-1], pid_out};
        ext_min = {sweep_min[SIG_W-1], sweep_min};
        ext_max = {sweep_max[SIG_W-1], sweep_max};
        if (sum_w >= ext_max) begin
            servo_dac = sweep_max;
        end else if (sum_w <= ext_min) begin
            servo_dac = sweep_min;
        end else begin
            servo_dac = offset + pid_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ST_IDLE;
            pid_on     <= 1'b0;
            pid_hld    <= 1'b0;
            locked     <= 1'b0;
            relock_cnt <= '0;
            timer      <= '0;
            loss       <= '0;
            offset     <= '0;
            dac_out    <= sweep_min;
        end else if (!en) begin
            st      <= ST_IDLE;
            pid_on  <= 1'b0;
            pid_hld <= 1'b0;
            locked  <= 1'b0;
            timer   <= '0;
            loss    <= '0;
            dac_out <= sweep_min;
        end else begin
            case (st)
                ST_IDLE: begin
                    st      <= ST_SWEEP;
                    pid_on  <= 1'b0;
                    pid_hld <= 1'b0;
                    locked  <= 1'b0;
                    dac_out <= ramp_next;
                end
                ST_SWEEP: begin
                    if (lock_hit) begin
                        st      <= ST_SETTLE;
                        offset  <= ramp_val;
                        timer   <= '0;
                        pid_on  <= 1'b1;
                        dac_out <= ramp_val;
                    end else begin
                        dac_out <= ramp_next;
                    end
                end
                ST_SETTLE: begin
                    if (lost_hit) begin
                        st      <= ST_SWEEP;
                        pid_on  <= 1'b0;
                        dac_out <= ramp_next;
                    end else if (timer >= settle_lim) begin
                        st      <= ST_LOCKED;
                        locked  <= 1'b1;
                        loss    <= '0;
                        pid_hld <= 1'b0;
                        dac_out <= servo_dac;
                    end else begin
                        if (timer != '1) begin
                            timer <= timer + CNT_ONE;
                        end
                        dac_out <= servo_dac;
                    end
                end
                ST_LOCKED: begin
                    dac_out <= servo_dac;
                    if (lost_hit) begin
                        if (loss >= lost_lim) begin
                            st      <= ST_SWEEP;
                            pid_on  <= 1'b0;
                            pid_hld <= 1'b0;
                            locked  <= 1'b0;
                            loss    <= '0;
                            dac_out <= ramp_next;
                            if (relock_cnt != RELOCK_MAX) begin
                                relock_cnt <= relock_cnt + 8'd1;
                            end
                        end else begin
                            if (loss != '1) begin
                                loss <= loss + CNT_ONE;
                            end
                            pid_hld <= 1'b1;
                        end
                    end else begin
                        loss    <= '0;
                        pid_hld <= 1'b0;
                    end
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cav_relock.sv
// Directed vector bench for cav_relock: a per-cycle table for sweep/lock/loss
// behaviour, plus hand sequences for saturation, reset priority and ramp holds.
module tb_cav_relock;

    localparam int SIG_W = 25;
    localparam int CNT_W = 24;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic signed [SIG_W-1:0] trans;
    logic signed [SIG_W-1:0] thr_lock;
    logic signed [SIG_W-1:0] thr_lost;
    logic signed [SIG_W-1:0] sweep_min;
    logic signed [SIG_W-1:0] sweep_max;
    logic        [SIG_W-2:0] sweep_step;
    logic        [CNT_W-1:0] settle_cyc;
    logic        [CNT_W-1:0] lost_cyc;
    logic signed [SIG_W-1:0] pid_out;
    logic                    pid_on;
    logic                    pid_hld;
    logic signed [SIG_W-1:0] dac_out;
    logic        [1:0]       state;
    logic                    locked;
    logic        [7:0]       relock_cnt;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic en;
        int   trans;
        int   pid;
        int   st;
        int   dac;
        logic pon;
        logic hld;
        logic lck;
        int   rel;
    } vec_t;

    vec_t vq[$];

    cav_relock #(
        .SIG_W (SIG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .trans      (trans),
        .thr_lock   (thr_lock),
        .thr_lost   (thr_lost),
        .sweep_min  (sweep_min),
        .sweep_max  (sweep_max),
        .sweep_step (sweep_step),
        .settle_cyc (settle_cyc),
        .lost_cyc   (lost_cyc),
        .pid_out    (pid_out),
        .pid_on     (pid_on),
        .pid_hld    (pid_hld),
        .dac_out    (dac_out),
        .state      (state),
        .locked     (locked),
        .relock_cnt (relock_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic addv(input logic e, input int tr, input int pd, input int s, input int d,
                        input logic po, input logic h, input logic l, input int r);
        vec_t v;
        v.en = e; v.trans = tr; v.pid = pd; v.st = s; v.dac = d;
        v.pon = po; v.hld = h; v.lck = l; v.rel = r;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int ramp_exp[19] = '{-1000, -700, -400, -100, 200, 500, 800, 1000, 700, 400,
                         100, -200, -500, -800, -1000, -700, -400, -100, 200};

    initial begin
        int  found;
        rst        = 1'b1;
        en         = 1'b0;
        trans      = '0;
        thr_lock   = 25'sd500;
        thr_lost   = 25'sd100;
        sweep_min  = -25'sd1000;
        sweep_max  = 25'sd1000;
        sweep_step = 24'd300;
        settle_cyc = 24'd10;
        lost_cyc   = 24'd4;
        pid_out    = 25'sd50;

        // Sweep triangle, lock acquisition, settle timing, loss debounce, clamps.
        for (int i = 0; i < 19; i++) addv(1, 0, 50, 1, ramp_exp[i], 0, 0, 0, 0);
        addv(1, 600, 50, 2, 200, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) addv(1, 600, 50, 2, 250, 1, 0, 0, 0);
        addv(1, 600, 50, 3, 250, 1, 0, 1, 0);
        addv(1, 0, -300, 3, -100, 1, 1, 1, 0);
        addv(1, 0, 900, 3, 1000, 1, 1, 1, 0);
        addv(1, 0, -1500, 3, -1000, 1, 1, 1, 0);
        addv(1, 600, 800, 3, 1000, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) addv(1, 0, 50, 3, 250, 1, 1, 1, 0);
        addv(1, 0, 50, 1, 200, 0, 0, 0, 1);
        addv(1, 0, 50, 1, 500, 0, 0, 0, 1);
        addv(1, 600, 50, 2, 500, 1, 0, 0, 1);
        addv(0, 600, 50, 0, -1000, 0, 0, 0, 1);
        addv(1, 0, 50, 1, -1000, 0, 0, 0, 1);
        addv(1, 0, 50, 1, -700, 0, 0, 0, 1);
        addv(1, 600, 50, 2, -700, 1, 0, 0, 1);
        addv(1, 0, 50, 1, -700, 0, 0, 0, 1);
        addv(1, 0, 50, 1, -400, 0, 0, 0, 1);

        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_dac", dac_out, -1000);
        chk("rst_pid_on", pid_on, 0);
        chk("rst_pid_hld", pid_hld, 0);
        chk("rst_locked", locked, 0);
        chk("rst_relock", relock_cnt, 0);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            en      = vq[i].en;
            trans   = vq[i].trans;
            pid_out = vq[i].pid;
            tick();
            chk($sformatf("v%0d_state", i), state, vq[i].st);
            chk($sformatf("v%0d_dac", i), dac_out, vq[i].dac);
            chk($sformatf("v%0d_pid_on", i), pid_on, vq[i].pon);
            chk($sformatf("v%0d_pid_hld", i), pid_hld, vq[i].hld);
            chk($sformatf("v%0d_locked", i), locked, vq[i].lck);
            chk($sformatf("v%0d_relock", i), relock_cnt, vq[i].rel);
        end

        // Offset 900 with pid 500 clamps to max; zero counts act as one cycle.
        en = 1'b0; trans = '0;
        do_reset();
        sweep_step = 24'd100;
        settle_cyc = '0;
        lost_cyc   = '0;
        pid_out    = 25'sd500;
        en         = 1'b1;
        found      = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick();
            if (state == 2'd1 && dac_out == 25'sd900) found = 1;
        end
        chk("reach_900", found, 1);
        trans = 25'sd600;
        tick();
        chk("a_settle_state", state, 2);
        chk("a_settle_dac", dac_out, 900);
        tick();
        chk("a_locked_state", state, 3);
        chk("a_clamp_max", dac_out, 1000);
        chk("a_locked", locked, 1);
        trans = '0;
        tick();
        chk("a_loss_state", state, 1);
        chk("a_relock1", relock_cnt, 1);
        for (int k = 2; k <= 255; k++) begin
            trans = 25'sd600;
            tick();
            tick();
            trans = '0;
            tick();
        end
        chk("a_relock255", relock_cnt, 255);
        trans = 25'sd600;
        tick();
        tick();
        trans = '0;
        tick();
        chk("a_relock_sat", relock_cnt, 255);
        chk("a_sat_state", state, 1);

        // Reset in LOCKED wins over en; first move after release.
        trans = 25'sd600;
        tick();
        tick();
        chk("b_pre_state", state, 3);
        rst = 1'b1;
        tick();
        chk("b_rst_state", state, 0);
        chk("b_rst_pid_on", pid_on, 0);
        chk("b_rst_relock", relock_cnt, 0);
        chk("b_rst_locked", locked, 0);
        chk("b_rst_dac", dac_out, -1000);
        tick();
        chk("b_rst_hold", state, 0);
        rst   = 1'b0;
        trans = '0;
        tick();
        chk("b_release", state, 1);

        // Zero step holds the ramp; inverted limits pin it at sweep_min.
        en = 1'b0;
        do_reset();
        sweep_step = '0;
        en = 1'b1;
        tick();
        chk("c_step0_a", dac_out, -1000);
        tick();
        tick();
        chk("c_step0_b", dac_out, -1000);
        sweep_min  = 25'sd500;
        sweep_max  = -25'sd500;
        sweep_step = 24'd300;
        tick();
        chk("c_inv_a", dac_out, 500);
        tick();
        chk("c_inv_b", dac_out, 500);
        chk("c_inv_state", state, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
